// File: rtl/leglite_pkg.sv
// LEGLite shared opcode, ALU-select and control-bundle definitions.
// CTRL_TRACE_TIMESTAMP_EN adds a 16-bit timestamp field to trace records.
package leglite_pkg;

  localparam int CTRL_W = 10;

`ifdef CTRL_TRACE_TIMESTAMP_EN
  localparam int TS_W = 16;
`else
  localparam int TS_W = 0;
`endif

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_NOP  = 3'd1;
  localparam logic [2:0] OP_ILL  = 3'd2;
  localparam logic [2:0] OP_LD   = 3'd3;
  localparam logic [2:0] OP_ST   = 3'd4;
  localparam logic [2:0] OP_CBZ  = 3'd5;
  localparam logic [2:0] OP_ADDI = 3'd6;
  localparam logic [2:0] OP_ANDI = 3'd7;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_PASSB = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd4;

  typedef struct packed {
    logic       reg2loc;
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic [2:0] alu_select;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
  } ctrl_t;

  // Returns {err, opcode}; LD ignores reg2loc so only the low 9 bits match.
  function automatic logic [3:0] encode_ctrl(input ctrl_t b);
    logic [3:0] r;
    r = {1'b1, OP_ILL};
    unique case (1'b1)
      (b == {4'b0000, ALU_ADD, 3'b001}):
        r = {1'b0, OP_ADD};
      (b[CTRL_W-2:0] == {3'b011, ALU_ADD, 3'b011}):
        r = {1'b0, OP_LD};
      (b == {4'b1000, ALU_ADD, 3'b110}):
        r = {1'b0, OP_ST};
      (b == {4'b1100, ALU_PASSB, 3'b000}):
        r = {1'b0, OP_CBZ};
      (b == {4'b0000, ALU_ADD, 3'b011}):
        r = {1'b0, OP_ADDI};
      (b == {4'b0000, ALU_AND, 3'b011}):
        r = {1'b0, OP_ANDI};
      (b == '0):
        r = {1'b0, OP_NOP};
      default:
        r = {1'b1, OP_ILL};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with occupancy counter and full/empty flags.
// Accepts a push while full when a pop happens in the same cycle.
module trace_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 21
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_trace_encoder.sv
// Re-encodes retired LEGLite control bundles into opcode trace records.
// CTRL_TRACE_TIMESTAMP_EN appends a 16-bit cycle timestamp to each record.
module ctrl_trace_encoder
  import leglite_pkg::*;
#(
  parameter int PC_W  = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [PC_W-1:0]          pc,
  input  logic                     reg2loc,
  input  logic                     branch,
  input  logic                     memread,
  input  logic                     memtoreg,
  input  logic [2:0]               alu_select,
  input  logic                     memwrite,
  input  logic                     alusrc,
  input  logic                     regwrite,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W+5+TS_W-1:0]   out_rec,
  output logic [CNT_W-1:0]         drop_count,
  output logic                     busy
);

  localparam int REC_W = PC_W + 5 + TS_W;

  ctrl_t            bundle;
  logic [3:0]       enc;
  logic [REC_W-1:0] wdata;
  logic [REC_W-1:0] rdata;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push;
  logic             drop;
  logic             ovf_pend;

  assign bundle = '{
    reg2loc:    reg2loc,
    branch:     branch,
    memread:    memread,
    memtoreg:   memtoreg,
    alu_select: alu_select,
    memwrite:   memwrite,
    alusrc:     alusrc,
    regwrite:   regwrite
  };

  assign enc  = encode_ctrl(bundle);
  assign pop  = out_valid && out_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

`ifdef CTRL_TRACE_TIMESTAMP_EN
  logic [15:0] ts;

  always_ff @(posedge clock) begin
    if (reset) begin
      ts <= '0;
    end else begin
      ts <= ts + 1'b1;
    end
  end

  assign wdata = {ovf_pend, enc, pc, ts};
`else
  assign wdata = {ovf_pend, enc, pc};
`endif

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  // A drop arms ovf; the next accepted record carries it and disarms it.
  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_pend   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      ovf_pend <= 1'b1;
      if (drop_count != '1) begin
        drop_count <= drop_count + 1'b1;
      end
    end else if (push) begin
      ovf_pend <= 1'b0;
    end
  end

  assign out_valid = !empty;
  assign busy      = !empty;
  assign out_rec   = empty ? '0 : rdata;

endmodule

// File: tb/tb_ctrl_trace_encoder.sv
// Scoreboard bench for ctrl_trace_encoder: directed bundles, queue-based
// expected records, and a negedge monitor that checks each transfer.
module tb_ctrl_trace_encoder;

`ifdef CTRL_TRACE_TIMESTAMP_EN
  localparam int TSW = 16;
`else
  localparam int TSW = 0;
`endif
  localparam int PC_W = 16;
  localparam int RW   = PC_W + 5 + TSW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [15:0]   pc = '0;
  logic          reg2loc = 1'b0;
  logic          branch = 1'b0;
  logic          memread = 1'b0;
  logic          memtoreg = 1'b0;
  logic [2:0]    alu_select = '0;
  logic          memwrite = 1'b0;
  logic          alusrc = 1'b0;
  logic          regwrite = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [RW-1:0] out_rec;
  logic [7:0]    drop_count;
  logic          busy;

  int errors = 0;
  int checks = 0;
  logic [RW-1:0] q[$];
  logic [15:0] ts_m = '0;

  localparam logic [9:0] B_ADD  = 10'b0000_000_001;
  localparam logic [9:0] B_LD0  = 10'b0011_000_011;
  localparam logic [9:0] B_LD1  = 10'b1011_000_011;
  localparam logic [9:0] B_ST   = 10'b1000_000_110;
  localparam logic [9:0] B_CBZ  = 10'b1100_010_000;
  localparam logic [9:0] B_ADDI = 10'b0000_000_011;
  localparam logic [9:0] B_ANDI = 10'b0000_100_011;
  localparam logic [9:0] B_ILL  = 10'b0000_000_101;
  localparam logic [9:0] B_NOP  = 10'b0000_000_000;

  ctrl_trace_encoder dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .pc         (pc),
    .reg2loc    (reg2loc),
    .branch     (branch),
    .memread    (memread),
    .memtoreg   (memtoreg),
    .alu_select (alu_select),
    .memwrite   (memwrite),
    .alusrc     (alusrc),
    .regwrite   (regwrite),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rec    (out_rec),
    .drop_count (drop_count),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset) ts_m <= '0;
    else ts_m <= ts_m + 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk(input logic ovf, input logic err,
                                       input logic [2:0] op,
                                       input logic [15:0] p);
`ifdef CTRL_TRACE_TIMESTAMP_EN
    return {ovf, err, op, p, ts_m};
`else
    return {ovf, err, op, p};
`endif
  endfunction

  task automatic set_bundle(input logic [9:0] b);
    {reg2loc, branch, memread, memtoreg, alu_select,
     memwrite, alusrc, regwrite} = b;
  endtask

  task automatic send(input logic [9:0] b, input logic [15:0] p,
                      input logic [2:0] op, input logic err,
                      input logic acc, input logic ovf);
    set_bundle(b);
    pc = p;
    in_valid = 1'b1;
    if (acc) q.push_back(mk(ovf, err, op, p));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 50) begin
      idle(1);
      n++;
    end
    chk("drain_done", 64'(q.size()), 64'd0);
  endtask

  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rec actual=%h required=none", out_rec);
      end else begin
        chk("rec", 64'(out_rec), 64'(q.pop_front()));
      end
    end
  end

  initial begin
    idle(2);
    reset = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_out_rec", 64'(out_rec), 64'd0);

    // ADD with single-cycle latency, no bypass
    set_bundle(B_ADD);
    pc = 16'h0010;
    in_valid = 1'b1;
    q.push_back(mk(1'b0, 1'b0, 3'd0, 16'h0010));
    #1;
    chk("no_bypass", 64'(out_valid), 64'd0);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    chk("latency_valid", 64'(out_valid), 64'd1);
    idle(1);
    chk("after_pop_valid", 64'(out_valid), 64'd0);

    send(B_LD0,  16'h0100, 3'd3, 1'b0, 1'b1, 1'b0);
    send(B_LD1,  16'h0104, 3'd3, 1'b0, 1'b1, 1'b0);
    send(B_ST,   16'h0108, 3'd4, 1'b0, 1'b1, 1'b0);
    send(B_CBZ,  16'h010c, 3'd5, 1'b0, 1'b1, 1'b0);
    send(B_ADDI, 16'h0110, 3'd6, 1'b0, 1'b1, 1'b0);
    send(B_ANDI, 16'h0114, 3'd7, 1'b0, 1'b1, 1'b0);
    send(B_ILL,  16'h0118, 3'd2, 1'b1, 1'b1, 1'b0);
    send(B_NOP,  16'h011c, 3'd1, 1'b0, 1'b1, 1'b0);
    drain();

    // overflow: 6 pushes into 4 entries, then ovf-tagged push
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      send(B_ADDI, 16'h0200 + 16'(i), 3'd6, 1'b0, i < 4, 1'b0);
    chk("drop_2", 64'(drop_count), 64'd2);
    chk("stall_head0", 64'(out_rec), 64'(q[0]));
    idle(1);
    chk("stall_head1", 64'(out_rec), 64'(q[0]));
    chk("full_busy", 64'(busy), 64'd1);
    out_ready = 1'b1;
    send(B_ST, 16'h0300, 3'd4, 1'b0, 1'b1, 1'b1);
    drain();

    // full with simultaneous push and pop
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(B_CBZ, 16'h0400 + 16'(i), 3'd5, 1'b0, 1'b1, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++)
      send(B_ANDI, 16'h0500 + 16'(i), 3'd7, 1'b0, 1'b1, 1'b0);
    chk("pushpop_nodrop", 64'(drop_count), 64'd2);
    out_ready = 1'b0;
    send(B_ADD, 16'h0600, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("still_full_drop", 64'(drop_count), 64'd3);
    drain();

    // saturation; first record carries the pending ovf
    out_ready = 1'b0;
    send(B_LD0, 16'h0700, 3'd3, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i < 4; i++)
      send(B_LD0, 16'h0700 + 16'(i), 3'd3, 1'b0, 1'b1, 1'b0);
    set_bundle(B_ADD);
    in_valid = 1'b1;
    idle(260);
    in_valid = 1'b0;
    chk("drop_sat", 64'(drop_count), 64'd255);

    // reset mid-stream with a push in the reset cycle
    reset = 1'b1;
    in_valid = 1'b1;
    q.delete();
    idle(1);
    reset = 1'b0;
    in_valid = 1'b0;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_drop", 64'(drop_count), 64'd0);
    chk("mid_rst_rec", 64'(out_rec), 64'd0);
    out_ready = 1'b1;
    idle(4);
    send(B_ADD, 16'h0800, 3'd0, 1'b0, 1'b1, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
